cfg_target_bridge: RTL
======================

# cfg_target_bridge

Parametrised host-config access bridge: takes the single held-level config request (devsel/addr/wren/rden, one-cycle done) from host_if and routes it to one of NUM_TGT downstream slaves (flash, VPD, future I2C/sensor blocks) using the same held-level protocol. It adds address decoding for the selected target, illegal-request rejection, an optional per-access timeout watchdog, and a response code. It sits between host_if and the per-device wrappers, replacing per-device point-to-point wiring.

## Interface
- NUM_TGT, 4, number of downstream targets (2..16)
- ADDR_W, 15, request address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 4096, watchdog limit in clock_afu cycles (>=2)
- SEL_W, derived $clog2(NUM_TGT) (min 1), devsel width; not overridable
- clock_afu  in  1  single clock; all logic on rising edge
- reset_afu_n  in  1  reset, asynchronous assert, active-low
- cfg_brg_devsel  in  SEL_W  target select
- cfg_brg_addr  in  ADDR_W  address, stable while wren/rden held
- cfg_brg_wren  in  1  held high until brg_cfg_done, then cleared
- cfg_brg_wdata  in  DATA_W  write data, valid while wren=1
- cfg_brg_rden  in  1  held high until brg_cfg_done, then cleared
- brg_cfg_rdata  out  DATA_W  read data, valid while brg_cfg_done=1
- brg_cfg_done  out  1  one-cycle completion pulse
- brg_cfg_resp  out  2  00 OK, 10 SLVERR (target error / illegal request), 11 TIMEOUT
- tgt_req_addr  out  ADDR_W  registered address, shared by all targets
- tgt_req_wdata  out  DATA_W  registered write data, shared
- tgt_req_wren  out  NUM_TGT  one-hot held write strobe
- tgt_req_rden  out  NUM_TGT  one-hot held read strobe
- tgt_rsp_rdata  in  NUM_TGT*DATA_W  target i occupies bits [i*DATA_W +: DATA_W]
- tgt_rsp_done  in  NUM_TGT  per-target completion pulse
- tgt_rsp_err  in  NUM_TGT  per-target error, sampled with done
- brg_err_pulse  out  1  one-cycle pulse whenever resp != 00 is returned

## Operation
- FSM states: IDLE, BUSY, DONE, DRAIN.
- IDLE: on wren XOR rden with devsel < NUM_TGT, capture sel/addr/wdata/dir, go BUSY.
- IDLE: on wren AND rden, or devsel >= NUM_TGT, go DONE with resp 10, rdata 0; no target strobe.
- BUSY: tgt_req_wren[sel] or tgt_req_rden[sel] held high. On tgt_rsp_done[sel]: capture rdata (reads only; writes return 0), resp = tgt_rsp_err[sel] ? 10 : 00; drop strobe; go DONE.
- Done/err from unselected targets are ignored in every state.
- DONE: brg_cfg_done=1 (and brg_err_pulse if resp!=00) for exactly one cycle; go DRAIN.
- DRAIN: wait for wren=0 and rden=0, then IDLE. Prevents re-issue of a still-held request.
- Host dropping its request during BUSY (protocol violation): the access completes normally and done still pulses.
- All outputs reset to 0; FSM to IDLE. An asserted reset mid-access drops target strobes immediately; the access is lost with no done.

## Timing
- Request first high in cycle T → tgt_req_* high from T+1.
- Target done in cycle T+1+n → brg_cfg_done in cycle T+2+n. Minimum round trip 2 cycles (n=0).
- Illegal request → brg_cfg_done in cycle T+1.
- brg_cfg_rdata and brg_cfg_resp are registered and valid only during the done cycle. They hold their value afterwards but are not guaranteed.
- Earliest next accepted request: the cycle after wren/rden are both seen low in DRAIN.

## Configuration
- CFG_BRG_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT_CYC+1) clears on BUSY entry and increments each BUSY cycle. At count TIMEOUT_CYC-1 with no target done, strobe drops, resp=11, rdata=0, go DONE (done at T+1+TIMEOUT_CYC).
- If target done and timeout coincide in the same cycle, target done wins.
- Not defined: no counter; BUSY waits indefinitely; resp 11 is never produced.

## Structure
- Package cfg_brg_pkg: resp constants RESP_OK/RESP_SLVERR/RESP_TIMEOUT, state enum brg_state_t.
- One sub-module, cfg_brg_watchdog (clear, enable → expired), instantiated only under CFG_BRG_TIMEOUT_EN.

## Test plan
- Read target 2, addr 0x1234, target done after 3 cycles with rdata 0xDEADBEEF → tgt_req_rden=4'b0100 from T+1; done at T+5, rdata 0xDEADBEEF, resp 00.
- Write target 0, wdata 0xA5A5A5A5, tgt_rsp_err=1 with done → resp 10, brg_err_pulse=1, rdata 0.
- NUM_TGT=3, devsel=3 read → no target strobe; done at T+1, resp 10.
- wren and rden both high → resp 10, done at T+1; host holds request 5 more cycles → exactly one done, no target strobe.
- With TIMEOUT_CYC=8 and the macro defined, target silent → done at T+9, resp 11. A second run with done and timeout in the same cycle → resp 00.
- Reset asserted in BUSY → strobes low asynchronously; after release, FSM in IDLE and no done.

Source files
------------

// File: rtl/cfg_brg_pkg.sv
// Shared types for the host-config target bridge: response codes and FSM states.
package cfg_brg_pkg;

  localparam logic [1:0] RESP_OK      = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } brg_state_t;

endpackage

// File: rtl/cfg_brg_watchdog.sv
// Per-access watchdog: counts enabled cycles since the last clear and flags the
// final cycle of the allowed window. Only built when CFG_BRG_TIMEOUT_EN is defined.
module cfg_brg_watchdog #(
  parameter  int LIMIT = 4096,
  localparam int CW    = $clog2(LIMIT + 1)
) (
  input  logic clock_afu,
  input  logic reset_afu_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] cnt_q;

  // Fires while the count sits at LIMIT-1, so the owner leaves on that edge.
  assign expired = enable && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n)             cnt_q <= '0;
    else if (clear)               cnt_q <= '0;
    else if (enable && !expired)  cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/cfg_target_bridge.sv
// Routes the held-level host config request to one of NUM_TGT targets and
// returns a coded response. Define CFG_BRG_TIMEOUT_EN to add the BUSY watchdog.
module cfg_target_bridge
  import cfg_brg_pkg::*;
#(
  parameter  int NUM_TGT     = 4,
  parameter  int ADDR_W      = 15,
  parameter  int DATA_W      = 32,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int SEL_W       = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
  input  logic                      clock_afu,
  input  logic                      reset_afu_n,
  input  logic [SEL_W-1:0]          cfg_brg_devsel,
  input  logic [ADDR_W-1:0]         cfg_brg_addr,
  input  logic                      cfg_brg_wren,
  input  logic [DATA_W-1:0]         cfg_brg_wdata,
  input  logic                      cfg_brg_rden,
  output logic [DATA_W-1:0]         brg_cfg_rdata,
  output logic                      brg_cfg_done,
  output logic [1:0]                brg_cfg_resp,
  output logic [ADDR_W-1:0]         tgt_req_addr,
  output logic [DATA_W-1:0]         tgt_req_wdata,
  output logic [NUM_TGT-1:0]        tgt_req_wren,
  output logic [NUM_TGT-1:0]        tgt_req_rden,
  input  logic [NUM_TGT*DATA_W-1:0] tgt_rsp_rdata,
  input  logic [NUM_TGT-1:0]        tgt_rsp_done,
  input  logic [NUM_TGT-1:0]        tgt_rsp_err,
  output logic                      brg_err_pulse
);

  if (NUM_TGT < 2 || NUM_TGT > 16 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("cfg_target_bridge: NUM_TGT must be 2..16 and TIMEOUT_CYC >= 2");
  end

  brg_state_t state_q, state_nxt;

  logic [NUM_TGT-1:0][DATA_W-1:0] rsp_rdata;
  logic [SEL_W-1:0]               sel_q, sel_nxt;
  logic [NUM_TGT-1:0]             sel_oh;
  logic                           wr_q, wr_nxt;
  logic                           req_any, req_one, sel_legal;
  logic                           cap, fin, expired;
  logic [1:0]                     fin_resp;
  logic [DATA_W-1:0]              fin_rdata;

  assign rsp_rdata = tgt_rsp_rdata;
  assign req_any   = cfg_brg_wren | cfg_brg_rden;
  assign req_one   = cfg_brg_wren ^ cfg_brg_rden;
  assign sel_legal = int'(cfg_brg_devsel) < NUM_TGT;
  assign sel_oh    = NUM_TGT'(1) << sel_nxt;

`ifdef CFG_BRG_TIMEOUT_EN
  cfg_brg_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clock_afu   (clock_afu),
    .reset_afu_n (reset_afu_n),
    .clear       (state_q != BUSY),
    .enable      (state_q == BUSY),
    .expired     (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    wr_nxt    = wr_q;
    cap       = 1'b0;
    fin       = 1'b0;
    fin_resp  = RESP_OK;
    fin_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (req_one && sel_legal) begin
          cap       = 1'b1;
          sel_nxt   = cfg_brg_devsel;
          wr_nxt    = cfg_brg_wren;
          state_nxt = BUSY;
        end else if (req_any) begin
          fin       = 1'b1;
          fin_resp  = RESP_SLVERR;
          state_nxt = DONE;
        end
      end
      BUSY: begin
        // Target done takes priority over a same-cycle watchdog expiry.
        if (tgt_rsp_done[sel_q]) begin
          fin       = 1'b1;
          fin_resp  = tgt_rsp_err[sel_q] ? RESP_SLVERR : RESP_OK;
          fin_rdata = wr_q ? '0 : rsp_rdata[sel_q];
          state_nxt = DONE;
        end else if (expired) begin
          fin       = 1'b1;
          fin_resp  = RESP_TIMEOUT;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = DRAIN;
      DRAIN:   if (!req_any) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) state_q <= IDLE;
    else              state_q <= state_nxt;
  end

  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) begin
      sel_q         <= '0;
      wr_q          <= 1'b0;
      tgt_req_addr  <= '0;
      tgt_req_wdata <= '0;
      tgt_req_wren  <= '0;
      tgt_req_rden  <= '0;
      brg_cfg_done  <= 1'b0;
      brg_err_pulse <= 1'b0;
      brg_cfg_resp  <= RESP_OK;
      brg_cfg_rdata <= '0;
    end else begin
      if (cap) begin
        sel_q         <= sel_nxt;
        wr_q          <= wr_nxt;
        tgt_req_addr  <= cfg_brg_addr;
        tgt_req_wdata <= cfg_brg_wdata;
      end
      // Strobes track the next state so they rise on BUSY entry and fall on exit.
      tgt_req_wren  <= (state_nxt == BUSY &&  wr_nxt) ? sel_oh : '0;
      tgt_req_rden  <= (state_nxt == BUSY && !wr_nxt) ? sel_oh : '0;
      brg_cfg_done  <= fin;
      brg_err_pulse <= fin && (fin_resp != RESP_OK);
      if (fin) begin
        brg_cfg_resp  <= fin_resp;
        brg_cfg_rdata <= fin_rdata;
      end
    end
  end

endmodule
